// File: rtl/sst_pkg.sv
// Shared types and constants for the save-state initiator.
// The optional checksum byte is enabled with SST_SUM_EN.
package sst_pkg;

  localparam int unsigned REG_CNT_DEF  = 128;
  localparam int unsigned SST_IDX_ADDR = 127;

  typedef enum logic [3:0] {
    IDLE,
    S_ADDR,
    S_CAP,
    S_PUSH,
    R_WAIT,
    R_WR,
    FIN
`ifdef SST_SUM_EN
    ,
    S_SUM,
    R_SUM
`endif
  } sst_state_t;

endpackage

// File: rtl/sst_engine_if.sv
// Host control, host byte streams and mapper save-state bus of sst_engine.
// master = engine side, slave = host/mapper side.
interface sst_engine_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start_save;
  logic              start_rst;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;
  logic              sst_act;
  logic [ADDR_W-1:0] sst_addr;
  logic [7:0]        sst_dato;
  logic              sst_we_reg;
  logic [7:0]        sst_di;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        cfg_map_idx;

  modport master (
    input  start_save, start_rst, abort, sst_di, out_ready, in_data, in_valid, cfg_map_idx,
    output busy, done, err, sst_act, sst_addr, sst_dato, sst_we_reg, out_data, out_valid, in_ready
  );

  modport slave (
    output start_save, start_rst, abort, sst_di, out_ready, in_data, in_valid, cfg_map_idx,
    input  busy, done, err, sst_act, sst_addr, sst_dato, sst_we_reg, out_data, out_valid, in_ready
  );
endinterface

// File: rtl/sst_sum.sv
// 8-bit modular accumulator used for the optional checksum byte (SST_SUM_EN).
module sst_sum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_data,
  output logic [7:0] o_sum
);
  logic [7:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_sum <= '0;
    else if (i_clr) r_sum <= '0;
    else if (i_add) r_sum <= r_sum + i_data;
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/sst_engine.sv
// Save-state initiator: walks mapper registers streaming them to the host (save)
// or writes host bytes back (restore). Define SST_SUM_EN for a trailing checksum byte.
module sst_engine
  import sst_pkg::*;
#(
  parameter int unsigned REG_CNT = REG_CNT_DEF,
  parameter int unsigned ADDR_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  sst_engine_if.master bus
);
  localparam int unsigned CNT_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REG_CNT - 1);

  sst_state_t       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_out_data;
  logic [7:0]       r_dato;
  logic             r_err;
  logic             r_sup;

  logic w_start, w_inc, w_err_set, w_cap, w_in_acc, w_is_idx, w_idx_bad_in;
  logic w_sum_load;

  assign w_is_idx     = (32'(r_cnt) == SST_IDX_ADDR);
  assign w_idx_bad_in = w_is_idx && (bus.in_data != bus.cfg_map_idx);

`ifdef SST_SUM_EN
  logic [7:0] w_sum;

  sst_sum u_sum (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start),
    .i_add  (w_cap | w_in_acc),
    .i_data (w_cap ? bus.sst_di : bus.in_data),
    .o_sum  (w_sum)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_inc      = 1'b0;
    w_err_set  = 1'b0;
    w_cap      = 1'b0;
    w_in_acc   = 1'b0;
    w_sum_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_save) begin
          w_next  = S_ADDR;
          w_start = 1'b1;
        end else if (bus.start_rst) begin
          w_next  = R_WAIT;
          w_start = 1'b1;
        end
      end
      S_ADDR: w_next = S_CAP;
      S_CAP: begin
        w_cap     = 1'b1;
        w_err_set = w_is_idx && (bus.sst_di != bus.cfg_map_idx);
        w_next    = S_PUSH;
      end
      S_PUSH: begin
        if (bus.out_ready) begin
          if (r_cnt == LAST) begin
`ifdef SST_SUM_EN
            w_next     = S_SUM;
            w_sum_load = 1'b1;
`else
            w_next = FIN;
`endif
          end else begin
            w_inc  = 1'b1;
            w_next = S_ADDR;
          end
        end
      end
      R_WAIT: begin
        if (bus.in_valid) begin
          w_in_acc  = 1'b1;
          w_err_set = w_idx_bad_in;
          w_next    = R_WR;
        end
      end
      R_WR: begin
        if (r_cnt == LAST) begin
`ifdef SST_SUM_EN
          w_next = R_SUM;
`else
          w_next = FIN;
`endif
        end else begin
          w_inc  = 1'b1;
          w_next = R_WAIT;
        end
      end
`ifdef SST_SUM_EN
      S_SUM: if (bus.out_ready) w_next = FIN;
      R_SUM: begin
        if (bus.in_valid) begin
          w_err_set = (bus.in_data != w_sum);
          w_next    = FIN;
        end
      end
`endif
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Abort overrides every side effect decided above, including byte capture.
    if (bus.abort && (r_state != IDLE)) begin
      w_next     = IDLE;
      w_err_set  = 1'b1;
      w_inc      = 1'b0;
      w_cap      = 1'b0;
      w_in_acc   = 1'b0;
      w_sum_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_out_data <= '0;
      r_dato     <= '0;
      r_err      <= 1'b0;
      r_sup      <= 1'b0;
    end else begin
      if (w_start)    r_cnt <= '0;
      else if (w_inc) r_cnt <= r_cnt + CNT_W'(1);

      if (w_cap) r_out_data <= bus.sst_di;
`ifdef SST_SUM_EN
      else if (w_sum_load) r_out_data <= w_sum;
`endif

      if (w_in_acc) begin
        r_dato <= bus.in_data;
        r_sup  <= w_idx_bad_in;
      end

      if (w_start)        r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    case (r_state)
      IDLE, FIN: bus.busy = 1'b0;
      default:   bus.busy = 1'b1;
    endcase
  end

  assign bus.sst_act    = bus.busy;
  assign bus.done       = (r_state == FIN);
  assign bus.err        = r_err;
  assign bus.sst_addr   = bus.busy ? ADDR_W'(r_cnt) : '0;
  assign bus.sst_dato   = r_dato;
  assign bus.sst_we_reg = (r_state == R_WR) && !r_sup;
  assign bus.out_data   = r_out_data;
`ifdef SST_SUM_EN
  assign bus.out_valid  = (r_state == S_PUSH) || (r_state == S_SUM);
  assign bus.in_ready   = (r_state == R_WAIT) || (r_state == R_SUM);
`else
  assign bus.out_valid  = (r_state == S_PUSH);
  assign bus.in_ready   = (r_state == R_WAIT);
`endif

endmodule

// File: tb/tb_sst_engine.sv
// Scoreboard bench for sst_engine: directed save/restore/abort sequences against a mapper model.
module tb_sst_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sst_engine_if #(.ADDR_W(8)) bus ();

  sst_engine #(.REG_CNT(128), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int n_done = 0;
  bit mon_en = 1'b0;
  bit rdy_toggle = 1'b0;
  int unsigned cyc = 0;
  logic [7:0] map_idx_byte = 8'd21;

  logic [7:0] exp_out[$];
  logic [7:0] exp_wa[$];
  logic [7:0] exp_wd[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mapper register model: read data valid one clock after the address.
  always @(posedge clk)
    bus.sst_di <= (bus.sst_addr == 8'd127) ? map_idx_byte : (bus.sst_addr ^ 8'h5A);

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1 bus.out_ready = rdy_toggle ? ((cyc % 3) == 0) : 1'b1;
    end
  end

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        n_chk++;
        if (exp_out.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out_byte: got 0x%0h, expected none", bus.out_data);
        end else begin
          n_chk--;
          chk("out_data", bus.out_data, exp_out.pop_front());
        end
      end
      if (prev_stall && bus.out_valid) chk("out_data_stable", bus.out_data, prev_data);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.sst_we_reg) begin
        n_chk++;
        if (exp_wa.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h, expected none", bus.sst_addr);
        end else begin
          n_chk--;
          chk("wr_addr", bus.sst_addr, exp_wa.pop_front());
          chk("wr_data", bus.sst_dato, exp_wd.pop_front());
        end
      end
      if (bus.done) n_done++;
    end
  end

  task automatic pulse_start(input bit sv, input bit rs);
    @(posedge clk); #1;
    bus.start_save = sv;
    bus.start_rst  = rs;
    @(posedge clk); #1;
    bus.start_save = 1'b0;
    bus.start_rst  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (!bus.sst_act) chk({name, "_sst_act_high"}, bus.sst_act, 1);
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, expected done", name);
    end else begin
      chk({name, "_fin_busy"}, bus.busy, 0);
      chk({name, "_fin_sst_act"}, bus.sst_act, 0);
      @(negedge clk);
      chk({name, "_done_one_cycle"}, bus.done, 0);
      chk({name, "_addr_idle"}, bus.sst_addr, 0);
    end
  endtask

  task automatic push_save_exp();
    logic [7:0] s = '0;
    logic [7:0] b;
    for (int unsigned a = 0; a < 128; a++) begin
      b = (a == 127) ? map_idx_byte : (8'(a) ^ 8'h5A);
      s = s + b;
      exp_out.push_back(b);
    end
`ifdef SST_SUM_EN
    exp_out.push_back(s);
`endif
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready 0, expected 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_restore(input logic [7:0] b127);
    logic [7:0] s = '0;
    logic [7:0] b;
    pulse_start(1'b0, 1'b1);
    chk("rst_err_cleared", bus.err, 0);
    for (int unsigned a = 0; a < 128; a++) begin
      b = (a == 127) ? b127 : 8'((a * 7 + 3) & 8'hFF);
      s = s + b;
      if (a != 127 || b127 == 8'd21) begin
        exp_wa.push_back(8'(a));
        exp_wd.push_back(b);
      end
      send_byte(b);
    end
`ifdef SST_SUM_EN
    send_byte(s);
`endif
    wait_done("restore");
    chk("restore_writes_drained", exp_wa.size(), 0);
  endtask

  initial begin
    int d0;
    bus.start_save  = 1'b0;
    bus.start_rst   = 1'b0;
    bus.abort       = 1'b0;
    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    bus.cfg_map_idx = 8'd21;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_sst_act", bus.sst_act, 0);
    chk("reset_addr", bus.sst_addr, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_we", bus.sst_we_reg, 0);
    chk("reset_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Save, host always ready
    push_save_exp();
    pulse_start(1'b1, 1'b0);
    chk("save_busy", bus.busy, 1);
    wait_done("save");
    chk("save_err", bus.err, 0);
    chk("save_drained", exp_out.size(), 0);

    // Save with stalling host
    rdy_toggle = 1'b1;
    push_save_exp();
    pulse_start(1'b1, 1'b0);
    wait_done("save_stall");
    chk("save_stall_drained", exp_out.size(), 0);
    rdy_toggle = 1'b0;

    // Restore, good index byte
    run_restore(8'd21);
    chk("restore_ok_err", bus.err, 0);

    // Restore, wrong index byte: write suppressed, err set
    run_restore(8'd23);
    chk("restore_bad_err", bus.err, 1);

    // Abort after 40 saved bytes
    push_save_exp();
    n_out = 0;
    d0 = n_done;
    pulse_start(1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (n_out >= 40) break;
    end
    chk("abort_bytes_before", n_out, 40);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_sst_act", bus.sst_act, 0);
    chk("abort_err", bus.err, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", n_done, d0);
    chk("abort_no_more_bytes", n_out, 40);
    exp_out.delete();

    push_save_exp();
    pulse_start(1'b1, 1'b0);
    chk("restart_err_cleared", bus.err, 0);
    wait_done("restart");
    chk("restart_drained", exp_out.size(), 0);

    // Simultaneous starts: save wins
    push_save_exp();
    pulse_start(1'b1, 1'b1);
    chk("both_in_ready", bus.in_ready, 0);
    wait_done("both");
    chk("both_drained", exp_out.size(), 0);
    chk("both_err", bus.err, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
